// File: rtl/jbcd_adder_manual_if.sv
// Digit-slice bus for the BCD adder: the two addend digits and carry-in travel in,
// the registered sum digit and decimal carry-out travel back.
interface jbcd_adder_manual_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       carryin;
  logic [3:0] Y;
  logic       carryout;

  // No valid/ready: the master presents a new digit pair every cycle and the
  // slave returns its result exactly one rising edge later.
  modport master (output A, output B, output carryin, input Y, input carryout);
  modport slave  (input A, input B, input carryin, output Y, output carryout);
endinterface

// File: rtl/jbcd_adder_manual.sv
// Single-digit BCD adder: gate-level binary ripple add, >9 detect, +6 correction,
// then a registered output stage so combinational glitches never reach the ports.
module jbcd_adder_manual (
  input logic                 clk,
  input logic                 rst_n,
  jbcd_adder_manual_if.slave  bus
);

  logic [4:0] w_c1;
  logic [3:0] w_s;
  logic       w_k;
  logic       w_c;
  logic [3:0] w_corr;
  logic [3:0] w_c2;
  logic [3:0] w_z;
  logic [3:0] r_y;
  logic       r_carry;

  assign w_c1[0] = bus.carryin;

  for (genvar i = 0; i < 4; i++) begin : g_add1
    assign w_s[i]    = bus.A[i] ^ bus.B[i] ^ w_c1[i];
    assign w_c1[i+1] = (bus.A[i] & bus.B[i]) | (w_c1[i] & (bus.A[i] ^ bus.B[i]));
  end

  assign w_k    = w_c1[4];
  assign w_c    = w_k | (w_s[3] & w_s[2]) | (w_s[3] & w_s[1]);
  assign w_corr = {1'b0, w_c, w_c, 1'b0};

  // The carry out of bit 3 of the correction chain is never built: it is discarded.
  assign w_c2[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_add2
    assign w_z[i] = w_s[i] ^ w_corr[i] ^ w_c2[i];
    if (i < 3) begin : g_cy
      assign w_c2[i+1] = (w_s[i] & w_corr[i]) | (w_c2[i] & (w_s[i] ^ w_corr[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= 4'd0;
      r_carry <= 1'b0;
    end else begin
      r_y     <= w_z;
      r_carry <= w_c;
    end
  end

  assign bus.Y        = r_y;
  assign bus.carryout = r_carry;

endmodule

// File: tb/tb_jbcd_adder_manual.sv
// Bench for the BCD digit adder: directed spec cases, exhaustive legal sweep and
// random non-BCD inputs, checked one cycle late through an expected-value queue.
module tb_jbcd_adder_manual;

  logic clk;
  logic rst_n;
  jbcd_adder_manual_if bus ();

  jbcd_adder_manual dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [4:0]  exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {co,Y}=%b_%0d expected %b_%0d", tag, got[4], got[3:0], exp[4], exp[3:0]);
    end
  endtask

  // Reference: binary sum, then decimal correction when above nine.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int s;
    s = int'(a) + int'(b) + int'(cin);
    if (s > 9) model = {1'b1, 4'((s + 6) % 16)};
    else       model = {1'b0, 4'(s)};
  endfunction

  // Driver: called away from the rising edge; drives, queues the expectation,
  // then compares just after the sampling edge and returns at the falling edge.
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic [4:0] exp);
    logic [4:0] e;
    bus.A       = a;
    bus.B       = b;
    bus.carryin = cin;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {bus.carryout, bus.Y}, e);
    end
    @(negedge clk);
  endtask

  logic [4:0] wide;

  initial begin
    rst_n       = 1'b0;
    bus.A       = 4'd9;
    bus.B       = 4'd9;
    bus.carryin = 1'b1;
    #2;
    check_eq("reset_async", {bus.carryout, bus.Y}, 5'b0_0000);
    @(negedge clk);
    check_eq("reset_held", {bus.carryout, bus.Y}, 5'b0_0000);
    rst_n = 1'b1;
    apply("reset_release", 4'd9, 4'd9, 1'b1, {1'b1, 4'd9});

    apply("nc_0+0", 4'd0, 4'd0, 1'b0, {1'b0, 4'd0});
    apply("nc_1+1", 4'd1, 4'd1, 1'b0, {1'b0, 4'd2});
    apply("nc_3+5", 4'd3, 4'd5, 1'b0, {1'b0, 4'd8});
    apply("nc_6+1", 4'd6, 4'd1, 1'b0, {1'b0, 4'd7});

    apply("cor_5+5", 4'd5, 4'd5, 1'b0, {1'b1, 4'd0});
    apply("cor_7+5", 4'd7, 4'd5, 1'b0, {1'b1, 4'd2});
    apply("cor_6+8", 4'd6, 4'd8, 1'b0, {1'b1, 4'd4});
    apply("cor_9+9", 4'd9, 4'd9, 1'b0, {1'b1, 4'd8});

    apply("cin_4+5", 4'd4, 4'd5, 1'b1, {1'b1, 4'd0});
    apply("cin_9+9", 4'd9, 4'd9, 1'b1, {1'b1, 4'd9});
    apply("cin_0+0", 4'd0, 4'd0, 1'b1, {1'b0, 4'd1});
    apply("cin_4+4", 4'd4, 4'd4, 1'b1, {1'b0, 4'd9});

    // Mid-operation reset clears outputs without waiting for a clock edge.
    apply("pre_rst", 4'd8, 4'd7, 1'b0, {1'b1, 4'd5});
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid", {bus.carryout, bus.Y}, 5'b0_0000);
    @(negedge clk);
    check_eq("reset_mid_hold", {bus.carryout, bus.Y}, 5'b0_0000);
    rst_n = 1'b1;

    // Exhaustive legal sweep, expected value is plain decimal A+B+cin.
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 2; c++) begin
          int s;
          logic [4:0] e;
          s = a + b + c;
          e = (s >= 10) ? {1'b1, 4'(s - 10)} : {1'b0, 4'(s)};
          apply("exhaustive", 4'(a), 4'(b), 1'(c), e);
        end
      end
    end

    wide = 5'd18;
    apply("nbcd_18+0", wide[3:0], 4'd0, 1'b0, {1'b0, 4'd2});
    apply("nbcd_15+15+1", 4'd15, 4'd15, 1'b1, {1'b1, 4'd5});
    apply("nbcd_10+0", 4'd10, 4'd0, 1'b0, {1'b1, 4'd0});

    for (int i = 0; i < 40; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      c = 1'($urandom_range(0, 1));
      apply("random", a, b, c, model(a, b, c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
